// File: rtl/usb_fifo_gpio_bridge_if.sv
// Pin bundle between the bridge, the FT245-style USB FIFO chip and the 32-bit USB GPIO PIO.
//   master : bridge side. It drives the chip strobes, the data bus output half and gpio_in.
//   slave  : chip/PIO side. It drives usb_d_in, usb_rxf_n, usb_txe_n and gpio_out.
interface usb_fifo_gpio_bridge_if;
  logic [7:0]  usb_d_in;
  logic [7:0]  usb_d_out;
  logic        usb_d_oe;
  logic        usb_rxf_n;
  logic        usb_txe_n;
  logic        usb_rd_n;
  logic        usb_wr_n;
  logic [31:0] gpio_out;
  logic [31:0] gpio_in;

  modport master (
    input  usb_d_in, usb_rxf_n, usb_txe_n, gpio_out,
    output usb_d_out, usb_d_oe, usb_rd_n, usb_wr_n, gpio_in
  );

  modport slave (
    output usb_d_in, usb_rxf_n, usb_txe_n, gpio_out,
    input  usb_d_out, usb_d_oe, usb_rd_n, usb_wr_n, gpio_in
  );
endinterface

// File: rtl/usb_fifo_gpio_bridge.sv
// Bridge between an FT245-style async USB FIFO chip and the USB GPIO PIO.
// Bytes read from the chip go into a small RX FIFO. Firmware pops them through a toggle bit
// and sends TX bytes through a second toggle bit. Status is returned on gpio_in, which is registered.
// Ports:
//   clk, reset_n : system clock (PIO domain); asynchronous active-low reset
//   bus          : usb_fifo_gpio_bridge_if.master
//                  - chip pins: usb_d_in/out/oe, usb_rxf_n, usb_txe_n, usb_rd_n, usb_wr_n
//                  - PIO ports: gpio_out (firmware commands), gpio_in (status)
module usb_fifo_gpio_bridge #(
  parameter int RD_PULSE   = 4,
  parameter int WR_PULSE   = 4,
  parameter int RECOVERY   = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  usb_fifo_gpio_bridge_if.master  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = 8;

  typedef enum logic [2:0] {IDLE, WR_SETUP, WR_STROBE, RD_STROBE, RECOVER} state_t;

  state_t          state;
  logic [TW-1:0]   tmr;
  logic            rxf_meta, rxf_sync, txe_meta, txe_sync;
  logic [7:0]      tx_byte;
  logic            tx_seen, tx_busy, tx_ack_toggle, pop_seen;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [4:0]      count;
  logic [7:0]      rx_head;

  logic [7:0] tx_data;
  logic       tx_toggle, rx_pop_toggle, rx_flush;
  logic       unused_gpio;
  assign tx_data       = bus.gpio_out[7:0];
  assign tx_toggle     = bus.gpio_out[8];
  assign rx_pop_toggle = bus.gpio_out[9];
  assign rx_flush      = bus.gpio_out[10];
  assign unused_gpio   = ^bus.gpio_out[31:11];

  logic tx_take, wr_go, rd_go, push, pop;
  // A TX accept blocks a read decision on the same cycle. This gives TX priority from the
  // moment it is seen, and reads stay blocked until the write has fully retired.
  assign tx_take = (state == IDLE) && !tx_busy && (tx_toggle != tx_seen);
  assign wr_go   = (state == IDLE) && tx_busy && !txe_sync;
  assign rd_go   = (state == IDLE) && !tx_busy && !tx_take && !rxf_sync &&
                   (count < 5'(FIFO_DEPTH)) && !rx_flush;
  // A read that finishes during a flush still completes on the pins. Its byte is dropped.
  assign push    = (state == RD_STROBE) && (tmr == '0) && !rx_flush;
  assign pop     = (rx_pop_toggle != pop_seen) && (count != '0) && !rx_flush;
  assign rx_head = (count != '0) ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rxf_meta <= 1'b1; rxf_sync <= 1'b1;
      txe_meta <= 1'b1; txe_sync <= 1'b1;
    end else begin
      rxf_meta <= bus.usb_rxf_n; rxf_sync <= rxf_meta;
      txe_meta <= bus.usb_txe_n; txe_sync <= txe_meta;
    end

  // Transfer FSM. All pin outputs are registered here.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state         <= IDLE;
      tmr           <= '0;
      bus.usb_rd_n  <= 1'b1;
      bus.usb_wr_n  <= 1'b1;
      bus.usb_d_oe  <= 1'b0;
      bus.usb_d_out <= 8'h00;
      tx_byte       <= 8'h00;
      tx_seen       <= 1'b0;
      tx_busy       <= 1'b0;
      tx_ack_toggle <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_take) begin
            tx_byte <= tx_data;
            tx_seen <= tx_toggle;
            tx_busy <= 1'b1;
          end
          if (wr_go) begin
            state         <= WR_SETUP;
            bus.usb_d_oe  <= 1'b1;
            bus.usb_d_out <= tx_byte;
          end else if (rd_go) begin
            state        <= RD_STROBE;
            bus.usb_rd_n <= 1'b0;
            tmr          <= TW'(RD_PULSE - 1);
          end
        end
        WR_SETUP: begin
          state        <= WR_STROBE;
          bus.usb_wr_n <= 1'b0;
          tmr          <= TW'(WR_PULSE - 1);
        end
        WR_STROBE:
          if (tmr == '0) begin
            state         <= RECOVER;
            bus.usb_wr_n  <= 1'b1;
            bus.usb_d_oe  <= 1'b0;
            tx_ack_toggle <= tx_seen;
            tmr           <= TW'(RECOVERY - 1);
          end else tmr <= tmr - 1'b1;
        RD_STROBE:
          if (tmr == '0) begin
            state        <= RECOVER;
            bus.usb_rd_n <= 1'b1;
            tmr          <= TW'(RECOVERY - 1);
          end else tmr <= tmr - 1'b1;
        RECOVER:
          if (tmr == '0) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
          end else tmr <= tmr - 1'b1;
        default: state <= IDLE;
      endcase
    end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.usb_d_in;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pop_seen <= 1'b0;
    end else begin
      // pop_seen always follows the toggle. A pop at empty or during a flush is consumed silently.
      pop_seen <= rx_pop_toggle;
      if (rx_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) bus.gpio_in <= 32'h0006_8000;
    else bus.gpio_in <= {13'h0, txe_sync, rxf_sync, (count == 5'(FIFO_DEPTH)),
                         (count == '0), tx_ack_toggle, tx_busy, count, rx_head};
endmodule

// File: tb/tb_usb_fifo_gpio_bridge.sv
module tb_usb_fifo_gpio_bridge;
  localparam int RD_PULSE = 4, WR_PULSE = 4, RECOVERY = 4, FIFO_DEPTH = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  usb_fifo_gpio_bridge_if bus ();

  usb_fifo_gpio_bridge #(.RD_PULSE(RD_PULSE), .WR_PULSE(WR_PULSE),
                         .RECOVERY(RECOVERY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.master));

  // Firmware and chip stimulus
  logic [7:0] tx_dat = 8'h00;
  logic       tx_tog = 1'b0, pop_tog = 1'b0, flush = 1'b0;
  logic       rxf_n = 1'b1, txe_n = 1'b1;
  logic [7:0] chip_byte = 8'h01;
  assign bus.gpio_out  = {21'h0, flush, pop_tog, tx_tog, tx_dat};
  assign bus.usb_rxf_n = rxf_n;
  assign bus.usb_txe_n = txe_n;
  assign bus.usb_d_in  = chip_byte;

  int errors = 0, checks = 0;
  logic [7:0] exp_q[$];
  int rd_count = 0, wr_pulses = 0, oe_rd_bad = 0;
  logic [7:0] last_wbyte = 8'h00;
  logic prev_wr_n = 1'b1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp_v);
    end
  endtask

  // Chip model: a read completes when rd_n rises out of reset. The byte then on the bus is
  // what the bridge should have stored, unless firmware is flushing.
  always @(posedge bus.usb_rd_n)
    if (reset_n === 1'b1) begin
      if (flush == 1'b0) exp_q.push_back(chip_byte);
      chip_byte = chip_byte + 8'd1;
      rd_count++;
    end

  always @(negedge clk) begin
    if (reset_n) begin
      if (!bus.usb_wr_n) begin
        if (prev_wr_n) wr_pulses++;
        last_wbyte = bus.usb_d_out;
      end
      if (bus.usb_d_oe && !bus.usb_rd_n) oe_rd_bad++;
    end
    prev_wr_n = bus.usb_wr_n;
  end

  function automatic logic [4:0] cnt_f(); return bus.gpio_in[12:8]; endfunction

  task automatic do_pop(input string tag);
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    chk(tag, bus.gpio_in[7:0], e);
    pop_tog = ~pop_tog;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic wait_rd(input logic v, input string tag);
    int n = 0;
    while (bus.usb_rd_n !== v && n < 60) begin @(negedge clk); n++; end
    chk(tag, bus.usb_rd_n, v);
  endtask

  task automatic one_read(input string tag);
    rxf_n = 1'b0;
    wait_rd(1'b0, {tag, "_start"});
    rxf_n = 1'b1;
    wait_rd(1'b1, {tag, "_end"});
    repeat (RECOVERY + 3) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) do_pop(tag);
    chk({tag, "_cnt"}, cnt_f(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r0, w0, first_oe, first_low, lowc, bad, maxc, start;
    logic saw_busy;

    // Reset values
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_gpio_in", bus.gpio_in, 32'h0006_8000);
    chk("rst_rd_n", bus.usb_rd_n, 1);
    chk("rst_wr_n", bus.usb_wr_n, 1);
    chk("rst_oe", bus.usb_d_oe, 0);
    chk("rst_dout", bus.usb_d_out, 0);

    // Reset asserted in the middle of RD_STROBE
    rxf_n = 1'b0;
    wait_rd(1'b0, "midrst_start");
    @(negedge clk);
    reset_n = 1'b0;
    #1 chk("midrst_rd_n_async", bus.usb_rd_n, 1);
    rxf_n = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_gpio_in", bus.gpio_in, 32'h0006_8000);

    // RX burst to full
    rxf_n = 1'b0;
    n = 0;
    while (bus.gpio_in[16] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    repeat (30) @(negedge clk);
    chk("burst_reads", rd_count, 16);
    chk("burst_count", cnt_f(), 16);
    chk("burst_full", bus.gpio_in[16], 1);
    do_pop("burst_head0");
    n = 0;
    while (rd_count < 17 && n < 40) begin @(negedge clk); n++; end
    chk("burst_17th_read", rd_count, 17);
    rxf_n = 1'b1;
    repeat (RECOVERY + 4) @(negedge clk);
    chk("burst_head1", bus.gpio_in[7:0], 8'h02);
    chk("burst_count2", cnt_f(), exp_q.size());
    drain("burst_drain");

    // Pop at empty: ignored, but pop_seen follows, so the next byte survives
    pop_tog = ~pop_tog;
    repeat (3) @(negedge clk);
    chk("pop0_count", cnt_f(), 0);
    chk("pop0_empty", bus.gpio_in[15], 1);
    one_read("pop0_rd");
    chk("pop0_seen", cnt_f(), 1);

    // Push and pop on the same edge at count 3
    one_read("co_rd1");
    one_read("co_rd2");
    chk("co_pre", cnt_f(), 3);
    rxf_n = 1'b0;
    wait_rd(1'b0, "co_start");
    rxf_n = 1'b1;
    repeat (RD_PULSE - 1) @(negedge clk);
    do_pop("co_head");
    chk("co_count", cnt_f(), 3);
    repeat (RECOVERY + 2) @(negedge clk);
    drain("co_drain");

    // Flush during RD_STROBE
    one_read("fl_rd1");
    rxf_n = 1'b0;
    wait_rd(1'b0, "fl_start");
    rxf_n = 1'b1;
    flush = 1'b1;
    exp_q.delete();
    wait_rd(1'b1, "fl_end");
    repeat (2) @(negedge clk);
    chk("fl_count", cnt_f(), 0);
    chk("fl_empty", bus.gpio_in[15], 1);
    flush = 1'b0;
    repeat (RECOVERY) @(negedge clk);
    one_read("fl_rd2");
    drain("fl_drain");

    // TX of 0xA5
    w0 = wr_pulses; first_oe = -1; first_low = -1; lowc = 0; bad = 0; saw_busy = 1'b0;
    txe_n = 1'b0;
    repeat (3) @(negedge clk);
    tx_dat = 8'hA5; tx_tog = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.gpio_in[13]) saw_busy = 1'b1;
      if (bus.usb_d_oe && first_oe < 0) first_oe = i;
      if (bus.usb_d_oe && bus.usb_d_out !== 8'hA5) bad++;
      if (!bus.usb_wr_n) begin
        lowc++;
        if (first_low < 0) first_low = i;
        if (!bus.usb_d_oe || bus.usb_d_out !== 8'hA5) bad++;
      end
    end
    chk("tx_low_cycles", lowc, WR_PULSE);
    chk("tx_oe_lead", first_low - first_oe, 1);
    chk("tx_data_bad", bad, 0);
    chk("tx_pulses", wr_pulses - w0, 1);
    chk("tx_busy_seen", saw_busy, 1);
    chk("tx_busy_clear", bus.gpio_in[13], 0);
    chk("tx_ack", bus.gpio_in[14], 1);
    chk("tx_oe_off", bus.usb_d_oe, 0);

    // TX stall blocks reads, then completes and reads resume
    txe_n = 1'b1;
    repeat (4) @(negedge clk);
    tx_dat = 8'h3C; tx_tog = 1'b0;
    repeat (5) @(negedge clk);
    chk("stall_busy", bus.gpio_in[13], 1);
    rxf_n = 1'b0;
    r0 = rd_count; w0 = wr_pulses;
    repeat (30) @(negedge clk);
    chk("stall_no_rd", rd_count - r0, 0);
    chk("stall_no_wr", wr_pulses - w0, 0);
    txe_n = 1'b0;
    n = 0;
    while (wr_pulses == w0 && n < 30) begin @(negedge clk); n++; end
    chk("stall_wr", wr_pulses - w0, 1);
    chk("stall_byte", last_wbyte, 8'h3C);
    chk("stall_rd_blocked_during_wr", rd_count - r0, 0);
    n = 0;
    while (rd_count == r0 && n < 40) begin @(negedge clk); n++; end
    chk("stall_rd_resume", rd_count > r0, 1);
    chk("stall_ack", bus.gpio_in[14], 0);
    rxf_n = 1'b1;
    txe_n = 1'b1;
    repeat (RD_PULSE + RECOVERY + 4) @(negedge clk);
    chk("stall_count", cnt_f(), exp_q.size());
    drain("stall_drain");

    // 40-byte stream with random interleaved pops across pointer wrap
    start = rd_count; maxc = 0;
    rxf_n = 1'b0;
    for (int cyc = 0; cyc < 4000 && !((rd_count - start) >= 40 && exp_q.size() == 0); cyc++) begin
      @(negedge clk);
      if (rd_count - start >= 40) rxf_n = 1'b1;
      if (int'(cnt_f()) > maxc) maxc = int'(cnt_f());
      if (cnt_f() != 0 && $urandom_range(0, 3) == 0) do_pop("wrap_head");
    end
    chk("wrap_reads", rd_count - start, 40);
    chk("wrap_max_le_depth", maxc <= FIFO_DEPTH, 1);
    repeat (3) @(negedge clk);
    chk("wrap_end_count", cnt_f(), 0);
    chk("oe_during_rd", oe_rd_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/usb_fifo_gpio_bridge.md
# usb_fifo_gpio_bridge

Bridges the FT245-style asynchronous USB FIFO chip pins to the 32-bit USB GPIO PIO of the current-control system. Sits directly in front of that PIO: its `gpio_in` drives the PIO input port, and it consumes the PIO output port as `gpio_out`. Bytes read from the USB chip are buffered in an internal RX FIFO. Firmware drives both directions through toggle handshakes on PIO bits. Status bits are active-low where the PIO falling-edge capture acts as an event flag.

## Interface
- RD_PULSE, 4: cycles `usb_rd_n` held low; data sampled on the last one (≥2).
- WR_PULSE, 4: cycles `usb_wr_n` held low (≥2).
- RECOVERY, 4: idle cycles after every transfer (≥3, covers the synchroniser).
- FIFO_DEPTH, 16: RX FIFO entries. Power of 2, ≤16.
- clk  in  1  system clock; PIO clock domain.
- reset_n  in  1  asynchronous, active-low.
- usb_d_in  in  8  chip data bus, input half.
- usb_d_out  out  8  chip data bus, output half.
- usb_d_oe  out  1  bus output enable; tristate lives at top level.
- usb_rxf_n  in  1  chip has RX data (low). Asynchronous.
- usb_txe_n  in  1  chip can accept TX data (low). Asynchronous.
- usb_rd_n  out  1  read strobe.
- usb_wr_n  out  1  write strobe.
- gpio_out  in  32  from PIO out_port:
  - [7:0] tx_data
  - [8] tx_toggle
  - [9] rx_pop_toggle
  - [10] rx_flush (level)
  - [31:11] ignored
- gpio_in  out  32  to PIO in_port, registered:
  - [7:0] rx_head
  - [12:8] rx_count
  - [13] tx_busy
  - [14] tx_ack_toggle
  - [15] rx_empty
  - [16] fifo_full
  - [17] rxf_n_sync
  - [18] txe_n_sync
  - [31:19] 0

## Operation
- `usb_rxf_n` and `usb_txe_n` pass through 2-FF synchronisers that reset to 1. `gpio_out` is same-domain and is not synchronised.
- **TX accept:** in IDLE state with tx_busy=0, if tx_toggle ≠ tx_seen:
  - latch tx_data;
  - set tx_seen ← tx_toggle;
  - set tx_busy=1.
  - A toggle while busy is not accepted. It is taken, with the then-current tx_data, once busy clears.
- **RX pop:** when rx_pop_toggle ≠ pop_seen, set pop_seen ← rx_pop_toggle.
  - If count>0: pop head.
  - If count=0: ignored.
  - Evaluated every cycle, independent of FSM state.
- **Flush:** while rx_flush=1:
  - pointers and count are held at 0;
  - no new read starts;
  - a read in progress completes on the pins, but its byte is discarded;
  - pops are tracked but have no effect.
- **FSM states:** IDLE, WR_SETUP, WR_STROBE, RD_STROBE, RECOVER.
- **IDLE:** TX has priority.
  - If tx_busy and txe_sync=0: go to WR_SETUP.
  - Else if rxf_sync=0 and count<FIFO_DEPTH and !rx_flush: go to RD_STROBE.
- **WR_SETUP** (1 cycle): usb_d_oe=1, usb_d_out=latched byte, usb_wr_n=1.
- **WR_STROBE** (WR_PULSE cycles): usb_d_oe=1, usb_wr_n=0. Then go to RECOVER.
  - On exit: tx_ack_toggle ← tx_seen.
  - tx_busy clears on leaving RECOVER.
- **RD_STROBE** (RD_PULSE cycles): usb_rd_n=0. On the final cycle edge, usb_d_in is pushed. Then go to RECOVER.
- **RECOVER** (RECOVERY cycles): all strobes high, usb_d_oe=0. Then go to IDLE.
- **usb_d_oe** is 1 only in the WR states. In RD_STROBE, usb_d_oe=0 is guaranteed.
- **Push and pop on the same edge:** both occur, count is unchanged.
  - A pop at count=FIFO_DEPTH cannot coincide with a push, because no read starts when full.
- **Pointers:** log2(FIFO_DEPTH) bits, wrap modulo depth. Count is 5 bits, range 0..FIFO_DEPTH.
- **rx_head** = mem[rd_ptr] when count>0, else 0x00.

## Timing
- **Reset values:**
  - usb_rd_n=1, usb_wr_n=1, usb_d_oe=0, usb_d_out=0x00;
  - FSM=IDLE, count=0, tx_seen=0, pop_seen=0, tx_busy=0, tx_ack_toggle=0;
  - gpio_in=0x0006_8000 (rx_empty=1, rxf/txe sync=1).
- Reset mid-transfer: strobes deassert asynchronously and the FIFO empties. The transfer on the pins is abandoned.
- Pin-to-FSM latency: 2 cycles synchroniser + 1 cycle IDLE decision.
- Count/pointers update on the action edge. gpio_in reflects the change one edge later.
- A write costs 1+WR_PULSE+RECOVERY cycles. A read costs RD_PULSE+RECOVERY cycles. IDLE adds ≥1 cycle between transfers.
- tx_busy: 1 from the accept edge until the RECOVER exit edge. gpio_in[13] lags it by one cycle.

## Test plan
- **Reset:** assert reset_n=0 mid-RD_STROBE → usb_rd_n=1 at once; after release, gpio_in=0x0006_8000.
- **RX burst:** chip holds rxf_n=0 and supplies bytes 0x01..0x11 → 16 bytes stored, fifo_full=1, rx_count=16, no 17th read. Pop once → 17th read occurs, head=0x02.
- **TX:** gpio_out = tx_toggle=1, tx_data=0xA5, with txe_n=0 → one usb_wr_n low pulse of 4 cycles, usb_d_out=0xA5 throughout with oe one cycle earlier, tx_ack_toggle=1, tx_busy 1→0.
- **TX stall and priority:** txe_n=1 with TX pending and rxf_n=0 → TX waits, no read occurs (TX has priority). txe_n→0 → write completes, then reads resume.
- **Pop/flush edges:**
  - pop at count=0 → ignored, pop_seen still updated;
  - push and pop on the same edge at count=3 → count stays 3;
  - rx_flush=1 during RD_STROBE → byte discarded, count=0, rx_empty=1.
- **Wrap:** 40 bytes streamed with interleaved pops → output order matches input order across pointer wrap, count never exceeds 16.
